display_mode_controller: RTL
============================

// Module: display_mode_controller
// PURPOSE
//  Game-level sequencer for the board display path. Tracks game phase (idle, playing,
//  game over, user quit) and generates the registered hex0hldr..hex5hldr and ledrhldr
//  codes consumed by FPGAdisplay. Handles binary-to-decimal split, blanking, game-over
//  blinking and match-flash timing. 4'hF is the blank code on every digit.
// PARAMETERS
//  BLINK_CYCLES     25_000_000  cycles per blink half-period in OVER (>=1)
//  FLASH_CYCLES     12_500_000  LEDR all-on duration after a match_pulse (>=1)
//  QUIT_HOLD_CYCLES 50_000_000  minimum cycles spent in QUIT (>=1)
// PORTS
//  CLOCK_50     in   1   sole clock, rising edge
//  reset        in   1   synchronous, active-high
//  userquit     in   1   level; quit request
//  ingameOn     in   1   level; game running
//  gameOver     in   1   level; game ended
//  mode         in   4   game mode shown on HEX0
//  score        in   7   binary score (0..127)
//  time_left    in   7   binary seconds remaining (0..127)
//  lives        in   4   lives remaining (0..15)
//  match_pulse  in   1   1-cycle strobe on a successful tile match
//  hex0hldr     out  4   digit code for HEX0
//  hex2hldr     out  4   time ones
//  hex3hldr     out  4   time tens
//  hex4hldr     out  4   score ones
//  hex5hldr     out  4   score tens
//  ledrhldr     out  10  LEDR pattern
// BEHAVIOUR
//  Reset: state=IDLE; hex0..hex5hldr=4'hF; ledrhldr=0; all counters=0; phase=1.
//  All outputs are registered. Inputs sampled at edge N are reflected on the outputs
//  after edge N, i.e. 1-cycle latency. Outputs are a function of next-state and inputs.
//  FSM (priority userquit > gameOver > ingameOn, evaluated every cycle):
//   IDLE -> QUIT on userquit; -> PLAY on ingameOn & !gameOver; else stay.
//   PLAY -> QUIT on userquit; -> OVER on gameOver; -> IDLE on !ingameOn.
//   OVER -> QUIT on userquit; -> PLAY on ingameOn & !gameOver;
//     -> IDLE on !gameOver & !ingameOn.
//   QUIT: hold counter loads QUIT_HOLD_CYCLES-1 on entry and counts down. Exit to IDLE
//     only when the counter is 0 and userquit=0. Otherwise stay.
//     userquit held high keeps the FSM in QUIT indefinitely.
//  Decimal split: v' = min(v,99); tens = v'/10; ones = v' mod 10.
//   Score tens digit 0 is shown as blank (4'hF). Time tens digit 0 is shown as 0.
//  Outputs per state:
//   IDLE: hex0=mode; hex2..hex5=F; ledr=0.
//   PLAY: hex0=mode; hex3/hex2=time; hex5/hex4=score.
//     ledr: all ones while flash counter != 0; otherwise thermometer of min(lives,10)
//     (lives=3 -> 10'b0000000111).
//   OVER: hex0=mode; hex3/hex2=F; hex5/hex4=score when phase=1, F when phase=0;
//     ledr=0.
//   QUIT: hex0=4'hE; hex2..hex5=F; ledr=0.
//  Flash counter:
//   - match_pulse in PLAY (or entering PLAY) loads FLASH_CYCLES and shows all-ones from
//     the next cycle; a pulse during a flash reloads it.
//   - Otherwise decrements to 0 (saturating).
//   - Leaving PLAY clears it; match_pulse outside PLAY is ignored.
//  Blink: on entry to OVER the blink counter is cleared and phase=1. phase toggles each
//   time the counter reaches BLINK_CYCLES-1; the counter then wraps to 0.
//  Reset asserted in any state overrides everything on that edge.
// TESTING
//  1 Reset in PLAY with score=45 -> next cycle: all hex=F, ledr=0, state IDLE.
//  2 ingameOn=1, mode=2, score=7, time_left=30, lives=3 -> hex0=2, hex5=F, hex4=7,
//    hex3=3, hex2=0, ledr=10'h007.
//  3 PLAY, FLASH_CYCLES=4, match_pulse at t -> ledr=3FF for 4 cycles, then 007;
//    second pulse at t+2 extends to t+6.
//  4 gameOver=1, score=120, BLINK_CYCLES=3 -> hex5/hex4=9/9 for 3 cycles, F/F for 3,
//    repeat; hex3/hex2=F.
//  5 userquit pulse 1 cycle, QUIT_HOLD_CYCLES=5 -> hex0=E for 5 cycles, then IDLE;
//    userquit held -> stays QUIT.
//  6 userquit & gameOver & ingameOn together from IDLE -> QUIT (priority); time_left=5
//    in PLAY -> hex3=0, hex2=5.

Source files
------------

// File: rtl/display_mode_controller.sv
// Game-phase sequencer for the board display path: tracks idle/play/over/quit and
// produces registered HEX digit codes and the LEDR pattern (4'hF blanks a digit).
module display_mode_controller #(
    parameter int unsigned BLINK_CYCLES     = 25_000_000,
    parameter int unsigned FLASH_CYCLES     = 12_500_000,
    parameter int unsigned QUIT_HOLD_CYCLES = 50_000_000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       userquit,
    input  logic       ingameOn,
    input  logic       gameOver,
    input  logic [3:0] mode,
    input  logic [6:0] score,
    input  logic [6:0] time_left,
    input  logic [3:0] lives,
    input  logic       match_pulse,
    output logic [3:0] hex0hldr,
    output logic [3:0] hex2hldr,
    output logic [3:0] hex3hldr,
    output logic [3:0] hex4hldr,
    output logic [3:0] hex5hldr,
    output logic [9:0] ledrhldr
);

    localparam int unsigned BlinkW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam int unsigned FlashW = $clog2(FLASH_CYCLES + 1);
    localparam int unsigned HoldW  = (QUIT_HOLD_CYCLES > 1) ? $clog2(QUIT_HOLD_CYCLES) : 1;

    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_CYCLES - 1);
    localparam logic [FlashW-1:0] FlashLoad = FlashW'(FLASH_CYCLES);
    localparam logic [HoldW-1:0]  HoldLoad  = HoldW'(QUIT_HOLD_CYCLES - 1);
    localparam logic [3:0]        Blank     = 4'hF;

    typedef enum logic [1:0] {StIdle, StPlay, StOver, StQuit} state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [HoldW-1:0]    r_hold,  w_hold_next;
    logic [FlashW-1:0]   r_flash, w_flash_next;
    logic [BlinkW-1:0]   r_blink, w_blink_next;
    logic                r_phase, w_phase_next;

    logic [6:0] w_score_sat, w_time_sat;
    logic [3:0] w_score_tens, w_score_ones, w_time_tens, w_time_ones;
    logic [3:0] w_lives_sat;
    logic [9:0] w_therm;
    logic [3:0] w_hex0, w_hex2, w_hex3, w_hex4, w_hex5;
    logic [9:0] w_ledr;

    // State, counters and registered outputs
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state  <= StIdle;
            r_hold   <= '0;
            r_flash  <= '0;
            r_blink  <= '0;
            r_phase  <= 1'b1;
            hex0hldr <= Blank;
            hex2hldr <= Blank;
            hex3hldr <= Blank;
            hex4hldr <= Blank;
            hex5hldr <= Blank;
            ledrhldr <= '0;
        end else begin
            r_state  <= w_state_next;
            r_hold   <= w_hold_next;
            r_flash  <= w_flash_next;
            r_blink  <= w_blink_next;
            r_phase  <= w_phase_next;
            hex0hldr <= w_hex0;
            hex2hldr <= w_hex2;
            hex3hldr <= w_hex3;
            hex4hldr <= w_hex4;
            hex5hldr <= w_hex5;
            ledrhldr <= w_ledr;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (userquit)                   w_state_next = StQuit;
                else if (ingameOn && !gameOver) w_state_next = StPlay;
            end
            StPlay: begin
                if (userquit)       w_state_next = StQuit;
                else if (gameOver)  w_state_next = StOver;
                else if (!ingameOn) w_state_next = StIdle;
            end
            StOver: begin
                if (userquit)                    w_state_next = StQuit;
                else if (ingameOn && !gameOver)  w_state_next = StPlay;
                else if (!gameOver && !ingameOn) w_state_next = StIdle;
            end
            StQuit: begin
                if (r_hold == '0 && !userquit) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Counters are keyed off the next state so outputs can reflect them immediately
    always_comb begin
        w_hold_next = r_hold;
        if (w_state_next == StQuit && r_state != StQuit) w_hold_next = HoldLoad;
        else if (r_state == StQuit && r_hold != '0)      w_hold_next = r_hold - 1'b1;

        if (w_state_next != StPlay)  w_flash_next = '0;
        else if (match_pulse)        w_flash_next = FlashLoad;
        else if (r_flash != '0)      w_flash_next = r_flash - 1'b1;
        else                         w_flash_next = '0;

        if (w_state_next != StOver || r_state != StOver) begin
            w_blink_next = '0;
            w_phase_next = 1'b1;
        end else if (r_blink == BlinkLast) begin
            w_blink_next = '0;
            w_phase_next = ~r_phase;
        end else begin
            w_blink_next = r_blink + 1'b1;
            w_phase_next = r_phase;
        end
    end

    always_comb begin
        w_score_sat  = (score > 7'd99) ? 7'd99 : score;
        w_time_sat   = (time_left > 7'd99) ? 7'd99 : time_left;
        w_score_tens = 4'(w_score_sat / 7'd10);
        w_score_ones = 4'(w_score_sat % 7'd10);
        w_time_tens  = 4'(w_time_sat / 7'd10);
        w_time_ones  = 4'(w_time_sat % 7'd10);
        w_lives_sat  = (lives > 4'd10) ? 4'd10 : lives;
        for (int i = 0; i < 10; i++) begin
            w_therm[i] = (4'(i) < w_lives_sat);
        end
    end

    always_comb begin
        w_hex0 = mode;
        w_hex2 = Blank;
        w_hex3 = Blank;
        w_hex4 = Blank;
        w_hex5 = Blank;
        w_ledr = '0;
        case (w_state_next)
            StPlay: begin
                w_hex3 = w_time_tens;
                w_hex2 = w_time_ones;
                w_hex5 = (w_score_tens == 4'd0) ? Blank : w_score_tens;
                w_hex4 = w_score_ones;
                w_ledr = (w_flash_next != '0) ? '1 : w_therm;
            end
            StOver: begin
                if (w_phase_next) begin
                    w_hex5 = (w_score_tens == 4'd0) ? Blank : w_score_tens;
                    w_hex4 = w_score_ones;
                end
            end
            StQuit:  w_hex0 = 4'hE;
            default: ;
        endcase
    end

endmodule
